// File: rtl/traffic_timer.sv
// -----------------------------------------------------------------------------
// traffic_timer
//
// Interval timer and one-second tick generator for the traffic-light
// sequencer. A one-cycle start request (st) with an interval select (sel)
// loads a duration from a small reprogrammable table. The timer counts that
// duration down on the divided tick (en) and returns a one-cycle expired
// pulse (ex) when it elapses.
//
// Parameters
//   DIV     clk cycles per tick (>= 2)
//   BASE_T  default base interval in ticks (1..15)
//   EXT_T   default extended interval in ticks (1..15)
//   YEL_T   default yellow interval in ticks (1..15)
//
// Ports
//   clk              in   single clock, rising edge
//   reset            in   synchronous, active-high
//   st               in   start / restart request
//   sel[1:0]         in   interval select: 00 base, 01 ext, 10 yellow, 11 base
//   reprogram        in   duration table write strobe
//   extTimeSelector  in   entry to write: 00 base, 01 ext, 10 yellow,
//                         11 restore all defaults
//   extTimeValue[3:0] in  value to write (0 is ignored)
//   en               out  one-cycle tick every DIV cycles
//   ex               out  one-cycle interval-expired pulse
//   busy             out  high while an interval is running
//   tv[3:0]          out  duration latched at the most recent start
//   remaining[3:0]   out  ticks left in the current interval
// -----------------------------------------------------------------------------
module traffic_timer #(
    parameter int DIV    = 50_000_000,
    parameter int BASE_T = 6,
    parameter int EXT_T  = 3,
    parameter int YEL_T  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       st,
    input  logic [1:0] sel,
    input  logic       reprogram,
    input  logic [1:0] extTimeSelector,
    input  logic [3:0] extTimeValue,
    output logic       en,
    output logic       ex,
    output logic       busy,
    output logic [3:0] tv,
    output logic [3:0] remaining
);

    // Keep a duration inside the legal 1..15 range so that an out-of-range
    // parameter can never produce a zero-length or truncated interval.
    function automatic logic [3:0] clamp_dur(input int v);
        if (v < 1) begin
            return 4'd1;
        end else if (v > 15) begin
            return 4'd15;
        end else begin
            return 4'(v);
        end
    endfunction

    // Table lookup for a start request; select 11 aliases to base.
    function automatic logic [3:0] pick_dur(input logic [1:0] s,
                                            input logic [3:0] b,
                                            input logic [3:0] e,
                                            input logic [3:0] y);
        case (s)
            2'b01:   return e;
            2'b10:   return y;
            default: return b;
        endcase
    endfunction

    localparam int              CNT_W    = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    localparam logic [3:0] BASE_DEF = clamp_dur(BASE_T);
    localparam logic [3:0] EXT_DEF  = clamp_dur(EXT_T);
    localparam logic [3:0] YEL_DEF  = clamp_dur(YEL_T);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       remaining_nxt;
    logic [3:0]       tv_nxt;
    logic             ex_nxt;
    logic [3:0]       base_dur, base_nxt;
    logic [3:0]       ext_dur, ext_nxt;
    logic [3:0]       yel_dur, yel_nxt;
    logic [3:0]       load_dur;

    // ------------------------------------------------------------------
    // Tick divider
    // ------------------------------------------------------------------
    assign en = (cnt == CNT_LAST);

    // A start realigns the divider so that the first decrement lands
    // exactly DIV cycles after the start edge.
    always_comb begin
        cnt_nxt = en ? '0 : cnt + CNT_W'(1);
        if (st) begin
            cnt_nxt = '0;
        end
    end

    // ------------------------------------------------------------------
    // Duration table
    // ------------------------------------------------------------------
    always_comb begin
        base_nxt = base_dur;
        ext_nxt  = ext_dur;
        yel_nxt  = yel_dur;
        if (reprogram) begin
            case (extTimeSelector)
                2'b00: if (extTimeValue != 4'd0) base_nxt = extTimeValue;
                2'b01: if (extTimeValue != 4'd0) ext_nxt  = extTimeValue;
                2'b10: if (extTimeValue != 4'd0) yel_nxt  = extTimeValue;
                default: begin
                    base_nxt = BASE_DEF;
                    ext_nxt  = EXT_DEF;
                    yel_nxt  = YEL_DEF;
                end
            endcase
        end
    end

    // Starts read the registered table, so a write in the same cycle as a
    // start only affects later starts.
    assign load_dur = pick_dur(sel, base_dur, ext_dur, yel_dur);

    // ------------------------------------------------------------------
    // Interval FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        tv_nxt        = tv;
        ex_nxt        = 1'b0;
        unique case (state)
            IDLE: begin
                if (st) begin
                    state_nxt     = RUN;
                    remaining_nxt = load_dur;
                    tv_nxt        = load_dur;
                end
            end
            RUN: begin
                // Restart has priority over a coincident tick, including
                // the final one, so a restarted interval never reports ex.
                if (st) begin
                    remaining_nxt = load_dur;
                    tv_nxt        = load_dur;
                end else if (en) begin
                    if (remaining > 4'd1) begin
                        remaining_nxt = remaining - 4'd1;
                    end else begin
                        remaining_nxt = 4'd0;
                        ex_nxt        = 1'b1;
                        state_nxt     = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state == RUN);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            remaining <= 4'd0;
            tv        <= 4'd0;
            ex        <= 1'b0;
            base_dur  <= BASE_DEF;
            ext_dur   <= EXT_DEF;
            yel_dur   <= YEL_DEF;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            remaining <= remaining_nxt;
            tv        <= tv_nxt;
            ex        <= ex_nxt;
            base_dur  <= base_nxt;
            ext_dur   <= ext_nxt;
            yel_dur   <= yel_nxt;
        end
    end

endmodule

// File: tb/tb_traffic_timer.sv
// -----------------------------------------------------------------------------
// tb_traffic_timer
//
// Directed bench for traffic_timer with DIV = 4. Each accepted start pushes
// the expected ex cycle and duration into a queue; an independent monitor
// pops an entry on every ex pulse and checks the time and duration.
// -----------------------------------------------------------------------------
module tb_traffic_timer;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       st = 1'b0;
    logic [1:0] sel = 2'b00;
    logic       reprogram = 1'b0;
    logic [1:0] ext_sel = 2'b00;
    logic [3:0] ext_val = 4'd0;
    logic       en;
    logic       ex;
    logic       busy;
    logic [3:0] tv;
    logic [3:0] remaining;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int t;
        int n;
    } exp_t;

    exp_t q[$];

    traffic_timer #(
        .DIV   (DIV),
        .BASE_T(6),
        .EXT_T (3),
        .YEL_T (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .st             (st),
        .sel            (sel),
        .reprogram      (reprogram),
        .extTimeSelector(ext_sel),
        .extTimeValue   (ext_val),
        .en             (en),
        .ex             (ex),
        .busy           (busy),
        .tv             (tv),
        .remaining      (remaining)
    );

    always #5 clk = ~clk;

    // cyc equals the number of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every ex pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (ex === 1'b1) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ex: got ex at cycle %0d want none", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("ex_time", cyc, e.t);
                chk("ex_tv", int'(tv), e.n);
                chk("ex_busy", int'(busy), 0);
                chk("ex_remaining", int'(remaining), 0);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issue a start; restart=1 drops the expectation of the interval it cancels.
    task automatic start(input logic [1:0] s, input int n, input bit restart,
                         input string tag);
        exp_t e;
        st  = 1'b1;
        sel = s;
        if (restart && q.size() > 0) q.delete(q.size() - 1);
        @(posedge clk);
        #1;
        st        = 1'b0;
        reprogram = 1'b0;
        e.t = cyc + n * DIV;
        e.n = n;
        q.push_back(e);
        chk({tag, "_tv"}, int'(tv), n);
        chk({tag, "_remaining"}, int'(remaining), n);
        chk({tag, "_busy"}, int'(busy), 1);
    endtask

    task automatic write_tbl(input logic [1:0] s, input logic [3:0] v);
        reprogram = 1'b1;
        ext_sel   = s;
        ext_val   = v;
        @(posedge clk);
        #1;
        reprogram = 1'b0;
    endtask

    task automatic drain(input string tag);
        int c = 0;
        while (q.size() != 0 && c < 300) begin
            @(posedge clk);
            c++;
        end
        #1;
        chk({tag, "_drain"}, q.size(), 0);
        q.delete();
        step(2);
    endtask

    task automatic wait_ex(input string tag);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (ex !== 1'b1 && c < 100);
        chk({tag, "_wait_ex"}, int'(ex), 1);
        #1;
    endtask

    initial begin
        int n_en;
        int n_busy;

        // Reset defaults
        step(2);
        chk("rst_ex", int'(ex), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_tv", int'(tv), 0);
        chk("rst_remaining", int'(remaining), 0);
        chk("rst_en", int'(en), 0);
        reset = 1'b0;
        n_en = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (en === 1'b1) n_en++;
        end
        chk("en_count_8cyc", n_en, 2);

        // Base interval: 6 ticks = 24 cycles, busy throughout
        start(2'b00, 6, 1'b0, "base");
        n_busy = 0;
        for (int i = 0; i < 23; i++) begin
            step(1);
            if (busy === 1'b1) n_busy++;
        end
        chk("base_busy_hold", n_busy, 23);
        drain("base");

        // Reprogram extended, zero write ignored, restore defaults
        write_tbl(2'b01, 4'd5);
        start(2'b01, 5, 1'b0, "ext5");
        drain("ext5");
        write_tbl(2'b01, 4'd0);
        start(2'b01, 5, 1'b0, "ext_zero");
        drain("ext_zero");
        write_tbl(2'b11, 4'd0);
        start(2'b01, 3, 1'b0, "ext_def");
        drain("ext_def");

        // Write and start in the same cycle: start sees the old value
        reprogram = 1'b1;
        ext_sel   = 2'b10;
        ext_val   = 4'd9;
        start(2'b10, 2, 1'b0, "yel_same");
        drain("yel_same");
        start(2'b10, 9, 1'b0, "yel_new");
        drain("yel_new");

        // Restart at cycle 10 of a base interval
        write_tbl(2'b11, 4'd0);
        start(2'b00, 6, 1'b0, "rs_a");
        step(9);
        start(2'b10, 2, 1'b1, "rs_b");
        drain("restart");
        step(10);

        // Back-to-back: start during the ex cycle
        start(2'b10, 2, 1'b0, "b2b_a");
        wait_ex("b2b");
        start(2'b10, 2, 1'b0, "b2b_b");
        drain("b2b");

        // Start coincident with the final tick of the running interval
        start(2'b10, 2, 1'b0, "col_a");
        step(7);
        chk("col_en_pending", int'(en), 1);
        chk("col_remaining", int'(remaining), 1);
        start(2'b10, 2, 1'b1, "col_b");
        drain("collision");
        step(4);

        // Reset mid-run restores table and clears outputs
        write_tbl(2'b00, 4'd7);
        start(2'b00, 7, 1'b0, "pre_rst");
        step(11);
        reset = 1'b1;
        if (q.size() > 0) q.delete(q.size() - 1);
        step(1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_remaining", int'(remaining), 0);
        chk("midrst_tv", int'(tv), 0);
        chk("midrst_ex", int'(ex), 0);
        reset = 1'b0;
        step(20);
        chk("midrst_idle_busy", int'(busy), 0);
        start(2'b00, 6, 1'b0, "post_rst");
        drain("post_rst");
        step(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout at cycle %0d want finish", cyc);
        $fatal(1);
    end

endmodule
